// File: rtl/jtcop_sndcmd_pkg.sv
// Shared definitions for the sound command queue: FSM state encoding and
// the value the latch shows after reset.
package jtcop_sndcmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] LATCH_RST = 8'hff;

endpackage

// File: rtl/jtcop_sndcmd_fifo.sv
// Dual-pointer register FIFO for queued sound commands. Pointers carry one
// extra MSB so that occupancy 2**AW (full) is distinguishable from empty.
// The head entry is visible combinationally on dout; the consumer registers it.
// Only instantiated when JTCOP_SNDCMD_FIFO_EN is defined.
module jtcop_sndcmd_fifo
  import jtcop_sndcmd_pkg::*;
#(
  parameter int AW = 2
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;

  logic [7:0]  mem_reg [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        wr_en;
  logic        rd_en;

  // A pop frees a slot in the same cycle, so a write to a full FIFO is taken
  // when it coincides with a pop.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  // Pointer registers; both wrap naturally modulo 2**(AW+1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage array; contents need no reset since the pointers gate validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_ptr_reg[AW-1:0]] <= din;
  end

  assign dout  = mem_reg[rd_ptr_reg[AW-1:0]];
  assign level = wr_ptr_reg - rd_ptr_reg;
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = level[AW];

endmodule

// File: rtl/jtcop_sndcmd.sv
// Sound command queue between the main CPU latch decode and the sound CPU.
// Presents one command at a time on latch with a clean snreq rising edge,
// waits for the sound CPU to read it (or for the watchdog), then keeps
// snreq low for at least GAP+1 cycles before the next command.
// Build option: define JTCOP_SNDCMD_FIFO_EN for the queued version; without
// it a single register behaves like the original board (last write wins).
module jtcop_sndcmd
  import jtcop_sndcmd_pkg::*;
#(
  parameter int AW   = 2,
  parameter int GAP  = 8,
  parameter int TOUT = 16
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          main_we,
  input  logic [7:0]    main_din,
  input  logic          snd_ack,
  output logic [7:0]    latch,
  output logic          snreq,
  output logic          full,
  output logic          ovf,
  output logic          tout,
  output logic [AW:0]   level
);

  localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);

  state_t            state_reg, state_next;
  logic [7:0]        latch_reg, latch_next;
  logic              snreq_reg, snreq_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic [TOUT-1:0]   wd_reg, wd_next;
  logic              tout_reg, tout_next;
  logic              pop;
  logic              cmd_avail;
  logic [7:0]        cmd_byte;

`ifdef JTCOP_SNDCMD_FIFO_EN
  logic       fifo_empty;
  logic       fifo_full;
  logic [7:0] fifo_dout;
  logic       ovf_reg;

  jtcop_sndcmd_fifo #(.AW(AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (main_we),
    .pop   (pop),
    .din   (main_din),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

  assign cmd_avail = ~fifo_empty;
  assign cmd_byte  = fifo_dout;
  assign full      = fifo_full;
  assign ovf       = ovf_reg;

  // Sticky overflow: a write that found the FIFO full with no pop to make room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_reg <= 1'b0;
    else        ovf_reg <= ovf_reg | (main_we & fifo_full & ~pop);
  end
`else
  logic pending_reg;

  // The byte already sits in latch; pending marks that it still needs a request.
  assign cmd_avail = pending_reg;
  assign cmd_byte  = latch_reg;
  assign full      = 1'b0;
  assign ovf       = 1'b0;
  assign level     = '0;

  // A new write always re-arms the request, even in the cycle it is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_reg <= 1'b0;
    else        pending_reg <= main_we | (pending_reg & ~pop);
  end
`endif

  // Handshake state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      latch_reg <= LATCH_RST;
      snreq_reg <= 1'b0;
      cnt_reg   <= '0;
      wd_reg    <= '0;
      tout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      latch_reg <= latch_next;
      snreq_reg <= snreq_next;
      cnt_reg   <= cnt_next;
      wd_reg    <= wd_next;
      tout_reg  <= tout_next;
    end
  end

  // Next-state logic: present, wait for ack/watchdog, then enforce the low gap.
  always_comb begin
    state_next = state_reg;
    latch_next = latch_reg;
    snreq_next = snreq_reg;
    cnt_next   = cnt_reg;
    wd_next    = wd_reg;
    tout_next  = tout_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_avail) begin
          pop        = 1'b1;
          latch_next = cmd_byte;
          snreq_next = 1'b1;
          wd_next    = '0;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (snd_ack || (&wd_reg)) begin
          if (!snd_ack) tout_next = 1'b1;
          snreq_next = 1'b0;
          cnt_next   = GAP_LOAD;
          state_next = ST_GAP;
        end else begin
          wd_next = wd_reg + TOUT'(1);
        end
      end
      ST_GAP: begin
        if (cnt_reg == 8'd0) state_next = ST_IDLE;
        else                 cnt_next   = cnt_reg - 8'd1;
      end
      default: state_next = ST_IDLE;
    endcase
`ifndef JTCOP_SNDCMD_FIFO_EN
    // Without a queue, a write replaces the latch and restarts the low gap.
    if (main_we) begin
      latch_next = main_din;
      snreq_next = 1'b0;
      cnt_next   = GAP_LOAD;
      state_next = ST_GAP;
    end
`endif
  end

  assign latch = latch_reg;
  assign snreq = snreq_reg;
  assign tout  = tout_reg;

endmodule
